// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus for the fetch unit.
//   imem_req    : fetch request valid (fetch unit -> memory)
//   imem_addr   : word-aligned fetch address (fetch unit -> memory)
//   imem_ready  : memory accepts the request on an edge where imem_req && imem_ready
//   imem_rvalid : read data valid; responses come back in request order
//   imem_rdata  : instruction word returned by memory
// master = fetch unit side, slave = memory side.
`timescale 1ns/1ps
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues sequential word fetches, queues returned
// instructions with their PCs, and presents one instruction per cycle to decode.
// Redirects flush everything in flight; stale responses are counted off and
// dropped while in DRAIN.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   imem         : instruction-memory bus (master side)
//   redirect     : branch/jump taken, flush and refetch from redirect_pc
//   redirect_pc  : redirect target (low two bits ignored)
//   stall        : decode not ready, hold outputs
//   instr_valid  : instruction/pc_out/cnt_val_pl4 hold a real fetched instruction
//   instruction  : instruction word, NOP (addi x0,x0,0) when not valid
//   pc_out       : address of the instruction
//   cnt_val_pl4  : pc_out + 4 (wraps)
`timescale 1ns/1ps
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master imem,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    input  logic                stall,
    output logic                instr_valid,
    output logic [31:0]         instruction,
    output logic [31:0]         pc_out,
    output logic [31:0]         cnt_val_pl4
);

    localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(FQ_DEPTH);

    typedef enum logic {
        FETCH,
        DRAIN
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [31:0]        fetch_pc;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   discard;

    // PC tags of requests whose responses will be kept
    logic [31:0]        tag_mem [FQ_DEPTH];
    logic [PTR_W-1:0]   tag_wr;
    logic [PTR_W-1:0]   tag_rd;

    // Fetch queue of {pc, word}
    logic [31:0]        q_pc   [FQ_DEPTH];
    logic [31:0]        q_word [FQ_DEPTH];
    logic [PTR_W-1:0]   q_wr;
    logic [PTR_W-1:0]   q_rd;
    logic [CNT_W-1:0]   q_count;

    logic               accept;
    logic               rsp;
    logic               rsp_keep;
    logic               rsp_drop;
    logic               pop;
    logic [CNT_W:0]     credit_sum;
    logic               credit_ok;
    logic [CNT_W-1:0]   discard_after;
    logic [CNT_W-1:0]   redirect_discard;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    assign accept   = imem.imem_req && imem.imem_ready;
    assign rsp      = imem.imem_rvalid;
    assign rsp_drop = rsp && (discard != '0);
    assign rsp_keep = rsp && (discard == '0) && !redirect;
    assign pop      = !redirect && !stall && (q_count != '0);

    // Credit counts both requests in flight and queued words, so every
    // accepted request is guaranteed a queue slot when it returns.
    assign credit_sum = {1'b0, outstanding} + {1'b0, q_count} - {{CNT_W{1'b0}}, pop};
    assign credit_ok  = credit_sum < CREDIT_LIMIT;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next       = state;
        discard_after    = discard - CNT_W'(rsp_drop);
        // A response arriving on the redirect edge is already accounted for.
        redirect_discard = outstanding - CNT_W'(rsp);
        if (redirect) begin
            state_next = (redirect_discard != '0) ? DRAIN : FETCH;
        end else if (state == DRAIN) begin
            state_next = (discard_after == '0) ? FETCH : DRAIN;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = fetch_pc;
        if (!rst && (state == FETCH) && !redirect && credit_ok) begin
            imem.imem_req = 1'b1;
        end
    end

    // ---------------- Control and output register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
            q_count     <= '0;
            instr_valid <= 1'b0;
            instruction <= NOP;
            pc_out      <= '0;
            cnt_val_pl4 <= 32'd4;
        end else begin
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(rsp);
            if (redirect) begin
                fetch_pc    <= {redirect_pc[31:2], 2'b00};
                discard     <= redirect_discard;
                tag_wr      <= '0;
                tag_rd      <= '0;
                q_wr        <= '0;
                q_rd        <= '0;
                q_count     <= '0;
                instr_valid <= 1'b0;
                instruction <= NOP;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    tag_wr   <= tag_wr + PTR_W'(1);
                end
                if (rsp_drop) begin
                    discard <= discard_after;
                end
                if (rsp_keep) begin
                    tag_rd <= tag_rd + PTR_W'(1);
                    q_wr   <= q_wr + PTR_W'(1);
                end
                if (!stall) begin
                    if (q_count != '0) begin
                        instr_valid <= 1'b1;
                        instruction <= q_word[q_rd];
                        pc_out      <= q_pc[q_rd];
                        cnt_val_pl4 <= q_pc[q_rd] + 32'd4;
                        q_rd        <= q_rd + PTR_W'(1);
                    end else begin
                        instr_valid <= 1'b0;
                        instruction <= NOP;
                    end
                end
                q_count <= q_count + CNT_W'(rsp_keep) - CNT_W'(pop);
            end
        end
    end

    // ---------------- Tag FIFO and queue storage ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept) begin
                tag_mem[tag_wr] <= fetch_pc;
            end
            if (rsp_keep) begin
                q_pc[q_wr]   <= tag_mem[tag_rd];
                q_word[q_wr] <= imem.imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch. A memory model returns the request
// address as data after a programmable latency.
`timescale 1ns/1ps
module tb_instruction_fetch;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] cnt_val_pl4;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .pc_out      (pc_out),
        .cnt_val_pl4 (cnt_val_pl4)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned edge_n   = 0;
    int unsigned lat      = 1;
    int unsigned n;
    logic        inj      = 1'b0;
    logic        seen_req;
    logic [31:0] exp_pc;
    req_t        pend [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_pc"}, pc_out, pc);
        check({tag, "_instr"}, instruction, pc);
        check({tag, "_pl4"}, cnt_val_pl4, pc + 32'd4);
    endtask

    // One clock: memory drives its response at the falling edge, the request
    // is sampled after it settles, then the rising edge is taken.
    task automatic tick();
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        if (inj) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end else if (pend.size() > 0 && pend[0].due <= edge_n + 1) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = pend[0].addr;
            void'(pend.pop_front());
        end
        #1;
        seen_req = bus.imem_req;
        if (bus.imem_req && bus.imem_ready) begin
            pend.push_back('{addr: bus.imem_addr, due: edge_n + 1 + lat});
        end
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        pend.delete();
        tick();
        check({tag, "_req"}, 32'(seen_req), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr"}, instruction, 32'h0000_0013);
        check({tag, "_pc"}, pc_out, 32'd0);
        check({tag, "_pl4"}, cnt_val_pl4, 32'd4);
        check({tag, "_addr"}, bus.imem_addr, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        redirect        = 1'b0;
        redirect_pc     = '0;
        stall           = 1'b0;
        bus.imem_ready  = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;

        // Reset release with single-cycle memory: gapless stream from 0
        lat = 1;
        do_reset("rst0");
        tick();
        check("s1_v1", 32'(instr_valid), 32'd0);
        tick();
        check("s1_v2", 32'(instr_valid), 32'd0);
        tick();
        exp_pc = 32'd0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            check_out("s1_stream", exp_pc);
            exp_pc += 32'd4;
        end

        // Stall three cycles: outputs frozen, requests stop once credits run out
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("s2_hold", 32'h14);
            check("s2_req", 32'(seen_req), (i < 2) ? 32'd1 : 32'd0);
        end
        stall = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_out("s2_resume", exp_pc);
            exp_pc += 32'd4;
        end

        // Redirect with two requests in flight, latency 3
        lat = 3;
        do_reset("rst1");
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        #1;
        check("s3_addr", bus.imem_addr, 32'h100);
        check("s3_req_drain", 32'(bus.imem_req), 32'd0);
        check("s3_valid", 32'(instr_valid), 32'd0);
        n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        check("s3_wait", n, 32'd7);
        check_out("s3_first", 32'h100);
        tick();
        check_out("s3_next", 32'h104);

        // Redirect to an unaligned target while stalled
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        check("s4_valid", 32'(instr_valid), 32'd0);
        check("s4_instr", instruction, 32'h0000_0013);
        check("s4_addr", bus.imem_addr, 32'h100);
        tick();
        check("s4_hold", 32'(instr_valid), 32'd0);
        stall = 1'b0;
        n = 0;
        while (!instr_valid && n < 30) begin
            tick();
            n++;
        end
        check_out("s4_first", 32'h100);

        // Address wrap; redirect on the same edge as the only outstanding response
        lat = 1;
        do_reset("rst2");
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        #1;
        check("s5_addr", bus.imem_addr, 32'hFFFF_FFFC);
        check("s5_req", 32'(bus.imem_req), 32'd1);
        check("s5_valid", 32'(instr_valid), 32'd0);
        tick();
        check("s5_wrap", bus.imem_addr, 32'd0);
        tick();
        check("s5_lat", 32'(instr_valid), 32'd0);
        tick();
        check_out("s5_top", 32'hFFFF_FFFC);
        tick();
        check_out("s5_zero", 32'd0);

        // Reset while draining three stale requests
        lat = 5;
        do_reset("rst3");
        tick();
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        #1;
        check("s6_drain_req", 32'(bus.imem_req), 32'd0);
        check("s6_addr", bus.imem_addr, 32'h200);
        rst = 1'b1;
        pend.delete();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        check("s6_rst_req", 32'(seen_req), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("s6_addr_rst", bus.imem_addr, 32'd0);
        check("s6_req_fetch", 32'(bus.imem_req), 32'd1);
        check("s6_valid", 32'(instr_valid), 32'd0);
        check("s6_instr", instruction, 32'h0000_0013);
        lat = 1;
        tick();
        check("s6_v1", 32'(instr_valid), 32'd0);
        tick();
        check("s6_v2", 32'(instr_valid), 32'd0);
        tick();
        check_out("s6_first", 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
